bcd_count_mux7seg: RTL

Parametrised multi-digit BCD up/down counter that drives a time-multiplexed common-anode 7-segment display. The block runs entirely in the `clk_50MHz` domain and uses clock-enable ticks for both the count rate and the digit scan, so it creates no derived clocks. It sits directly behind the board's segment and anode pins and is the general-purpose count/display block for Cyclone III board projects.

---
 rtl/bcd_count_mux7seg.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_count_mux7seg.sv
// bcd_count_mux7seg: multi-digit BCD up/down counter driving a multiplexed common-anode 7-segment display
module bcd_count_mux7seg #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 12_500,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk_50MHz,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  wrap,
  output logic [6:0]            seg_led,
  output logic [0:DIGITS-1]     an
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0]       pre_q, pre_d;
  logic                tick, cnt, last;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, inc, dec, ld;
  logic [DIGITS:0]     cy, bw;
  logic [DIGITS:1]     hz;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          dig [DIGITS];
  logic                wrap_q, wrap_d;
  logic [DW-1:0]       dw_q, dw_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [0:DIGITS-1]   an_q, an_d;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign pre_d = (clear || tick) ? '0 : pre_q + 1'b1;
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  assign hz[DIGITS] = 1'b1;
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    assign dig[i] = bcd_q[4*i +: 4];
    assign inc[4*i +: 4] = !cy[i] ? dig[i] : dig[i] == 4'd9 ? 4'd0 : dig[i] + 4'd1;
    assign dec[4*i +: 4] = !bw[i] ? dig[i] : dig[i] == 4'd0 ? 4'd9 : dig[i] - 4'd1;
    assign cy[i+1] = cy[i] && dig[i] == 4'd9;
    assign bw[i+1] = bw[i] && dig[i] == 4'd0;
    assign ld[4*i +: 4] = load_val[4*i +: 4] > 4'd9 ? 4'd0 : load_val[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_hi
      // a zero digit is leading only if every digit above it is zero too
      if (i < DIGITS - 1) begin : g_mid
        assign hz[i] = hz[i+1] && dig[i] == 4'd0;
      end else begin : g_top
        assign hz[i] = dig[i] == 4'd0;
      end
      assign blank[i] = (BLANK_LZ != 0) && hz[i];
    end
  end
  assign cnt = tick && en && !clear && !load;
  assign bcd_d = clear ? '0 : load ? ld : cnt ? (up_dn ? inc : dec) : bcd_q;
  assign wrap_d = cnt && (up_dn ? cy[DIGITS] : bw[DIGITS]);
  assign last = dw_q == DW'(SCAN_DIV - 1);
  assign dw_d = last ? '0 : dw_q + 1'b1;
  assign idx_d = !last ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
  assign seg_d = blank[idx_q] ? 7'b1111111 : seg7(dig[idx_q]);
  always_comb begin
    an_d = '0;
    an_d[idx_q] = 1'b1;
  end
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      dw_q   <= '0;
      idx_q  <= '0;
      seg_q  <= 7'b0000001;
      an_q   <= '0;
      an_q[0] <= 1'b1;
    end else begin
      pre_q  <= pre_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      dw_q   <= dw_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end
  assign bcd_out = bcd_q;
  assign wrap = wrap_q;
  assign seg_led = seg_q;
  assign an = an_q;
endmodule
